updi_multi_target_seq: RTL and testbench



---
 rtl/updi_seq_pkg.sv | 36 +++
 rtl/updi_multi_target_seq_timer.sv | 40 ++++
 rtl/updi_multi_target_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_updi_multi_target_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/updi_seq_pkg.sv
// Shared types, defaults and sizing helpers for the multi-target UPDI sequencer.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package updi_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN,
        S_SETTLE,
        S_START,
        S_WAIT_BUSY,
        S_RUN,
        S_CHECK,
        S_ABORT,
        S_DONE
    } seq_state_t;

    // Defaults for a 100 MHz core clock: 10 us pin settle, 1 s programming watchdog.
    localparam int DEFAULT_SETTLE_CLKS      = 1000;
    localparam int DEFAULT_RUN_TIMEOUT_CLKS = 100_000_000;

    // Width of a down-counter able to hold the largest of the three loads.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    // Width of a target index; never below one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/updi_multi_target_seq_timer.sv
// Loadable down-counter shared by the settle, busy-wait and run-watchdog phases.
// Latency: load takes effect on the next clock; each enabled clock decrements by one, holding at zero.
// Backpressure: none; load has priority over en.
// Ports: clk, rst (async active-high), load/load_val, en -> value, zero (value == 0).
module updi_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (en && (value_q != '0)) begin
            value_d = value_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/updi_multi_target_seq.sv
// Steps one shared UPDI programmer across N_TARGETS pins: select, settle, start, watch, retry, report.
// Latency: SETTLE_CLKS from pin select to prog_start; done N_TARGETS+2 clocks after start for an empty mask.
// Backpressure: start is only accepted in IDLE; start pulses during a sequence are dropped.
// Ports: start/target_mask in; busy, done, pass_mask, fail_mask, cur_target out;
//        pin_sel (one-hot mux), prog_rst, prog_start to the programmer; prog_busy, phy_error from it.
// Build option: define UPDI_SEQ_STOP_ON_FAIL_EN to end the sequence at the first target that fails.
module updi_multi_target_seq
    import updi_seq_pkg::*;
#(
    parameter int N_TARGETS        = 4,
    parameter int MAX_RETRIES      = 2,
    parameter int SETTLE_CLKS      = DEFAULT_SETTLE_CLKS,
    parameter int BUSY_WAIT_CLKS   = 16,
    parameter int RUN_TIMEOUT_CLKS = DEFAULT_RUN_TIMEOUT_CLKS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [N_TARGETS-1:0]               target_mask,
    output logic                               busy,
    output logic                               done,
    output logic [N_TARGETS-1:0]               pass_mask,
    output logic [N_TARGETS-1:0]               fail_mask,
    output logic [sel_width(N_TARGETS)-1:0]    cur_target,
    output logic [N_TARGETS-1:0]               pin_sel,
    output logic                               prog_rst,
    output logic                               prog_start,
    input  logic                               prog_busy,
    input  logic                               phy_error
);

    localparam int CW = sel_width(N_TARGETS);
    localparam int TW = timer_width(SETTLE_CLKS, BUSY_WAIT_CLKS, RUN_TIMEOUT_CLKS);

    localparam logic [TW-1:0]        SETTLE_T = TW'(SETTLE_CLKS);
    localparam logic [TW-1:0]        BUSY_T   = TW'(BUSY_WAIT_CLKS);
    localparam logic [TW-1:0]        RUN_T    = TW'(RUN_TIMEOUT_CLKS);
    localparam logic [CW:0]          END_IDX  = (CW + 1)'(N_TARGETS);
    localparam logic [2:0]           MAX_R    = 3'(MAX_RETRIES);
    localparam logic [N_TARGETS-1:0] ONE      = N_TARGETS'(1);

    seq_state_t             state_q, state_d;
    logic [CW:0]            idx_q, idx_d;       // one extra bit so "past last" is representable
    logic [2:0]             retry_q, retry_d;
    logic                   err_q, err_d;       // sticky per-attempt error
    logic                   busy_q, busy_d;
    logic [N_TARGETS-1:0]   mask_q, mask_d;
    logic [N_TARGETS-1:0]   pass_q, pass_d;
    logic [N_TARGETS-1:0]   fail_q, fail_d;
    logic [N_TARGETS-1:0]   pin_q, pin_d;
    logic [CW-1:0]          cur_q, cur_d;

    logic                   tmr_load;
    logic [TW-1:0]          tmr_load_val;
    logic                   tmr_en;
    logic [TW-1:0]          tmr_value;
    logic                   tmr_zero;
    logic                   tmr_expire;

    logic [N_TARGETS-1:0]   mask_sh;
    logic                   mask_bit;
    logic                   past_last;
    logic [N_TARGETS-1:0]   onehot;

    updi_seq_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    // A phase loaded with K lasts exactly K clocks: it ends on the clock whose decrement
    // reaches zero (or immediately when K is zero).
    assign tmr_expire = tmr_zero || (tmr_value == TW'(1));

    // Shift instead of indexing so an index past the last target never selects out of range.
    assign mask_sh   = mask_q >> idx_q;
    assign mask_bit  = mask_sh[0];
    assign past_last = (idx_q >= END_IDX);
    assign onehot    = ONE << idx_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        err_d        = err_q;
        busy_d       = busy_q;
        mask_d       = mask_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        pin_d        = pin_q;
        cur_d        = cur_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;
        done         = 1'b0;
        prog_start   = 1'b0;
        prog_rst     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = target_mask;
                    pass_d  = '0;
                    fail_d  = '0;
                    idx_d   = '0;
                    retry_d = '0;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (past_last) begin
                    state_d = S_DONE;
                end else if (!mask_bit) begin
                    idx_d = idx_q + (CW + 1)'(1);
                end else begin
                    pin_d        = onehot;
                    cur_d        = idx_q[CW-1:0];
                    tmr_load     = 1'b1;
                    tmr_load_val = SETTLE_T;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                prog_start   = 1'b1;
                err_d        = 1'b0;
                tmr_load     = 1'b1;
                tmr_load_val = BUSY_T;
                state_d      = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (prog_busy) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = RUN_T;
                    state_d      = S_RUN;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expire) begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_RUN: begin
                if (phy_error) begin
                    err_d = 1'b1;
                end
                // Busy dropping wins over a watchdog expiring on the same clock.
                if (!prog_busy) begin
                    state_d = S_CHECK;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expire) begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_ABORT: begin
                prog_rst = 1'b1;
                err_d    = 1'b1;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                if (!err_q) begin
                    pass_d  = pass_q | onehot;
                    retry_d = '0;
                    idx_d   = idx_q + (CW + 1)'(1);
                    pin_d   = '0;
                    state_d = S_SCAN;
                end else if (retry_q < MAX_R) begin
                    retry_d      = retry_q + 3'd1;
                    tmr_load     = 1'b1;
                    tmr_load_val = SETTLE_T;
                    state_d      = S_SETTLE;
                end else begin
                    fail_d  = fail_q | onehot;
                    retry_d = '0;
                    idx_d   = idx_q + (CW + 1)'(1);
                    pin_d   = '0;
`ifdef UPDI_SEQ_STOP_ON_FAIL_EN
                    state_d = S_DONE;
`else
                    state_d = S_SCAN;
`endif
                end
            end
            S_DONE: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                pin_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            retry_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            mask_q  <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            pin_q   <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            pin_q   <= pin_d;
            cur_q   <= cur_d;
        end
    end

    assign busy       = busy_q;
    assign pass_mask  = pass_q;
    assign fail_mask  = fail_q;
    assign pin_sel    = pin_q;
    assign cur_target = cur_q;

endmodule

// File: tb/tb_updi_multi_target_seq.sv
// Self-checking bench for updi_multi_target_seq: table of sequences against a behavioural programmer.
// Timing reference: a phase loaded with K lasts K clocks, so prog_start follows a pin change by SETTLE_T,
// prog_rst follows prog_start by BUSY_T+1 (no busy) or RUN_T+2 (busy stuck: START, one WAIT_BUSY, RUN_T RUN).
module tb_updi_multi_target_seq;

    localparam int N        = 4;
    localparam int MAXR     = 2;
    localparam int SETTLE_T = 20;
    localparam int BUSY_T   = 16;
    localparam int RUN_T    = 100;
`ifdef UPDI_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    // Programmer behaviours, 3 bits per target in cur_beh (target 0 in [2:0]).
    localparam logic [2:0] B_OK     = 3'd0;  // busy 50 clks, clean
    localparam logic [2:0] B_ERR1   = 3'd1;  // phy_error on the first attempt only
    localparam logic [2:0] B_NOBUSY = 3'd2;  // never raises busy
    localparam logic [2:0] B_STUCK  = 3'd3;  // busy high until prog_rst
    localparam logic [2:0] B_EDGE   = 3'd4;  // busy falls on the watchdog expiry clock

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   target_mask;
    logic           busy;
    logic           done;
    logic [N-1:0]   pass_mask;
    logic [N-1:0]   fail_mask;
    logic [1:0]     cur_target;
    logic [N-1:0]   pin_sel;
    logic           prog_rst;
    logic           prog_start;
    logic           prog_busy;
    logic           phy_error;

    always #5 clk = ~clk;

    updi_multi_target_seq #(
        .N_TARGETS        (N),
        .MAX_RETRIES      (MAXR),
        .SETTLE_CLKS      (SETTLE_T),
        .BUSY_WAIT_CLKS   (BUSY_T),
        .RUN_TIMEOUT_CLKS (RUN_T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .target_mask (target_mask),
        .busy        (busy),
        .done        (done),
        .pass_mask   (pass_mask),
        .fail_mask   (fail_mask),
        .cur_target  (cur_target),
        .pin_sel     (pin_sel),
        .prog_rst    (prog_rst),
        .prog_start  (prog_start),
        .prog_busy   (prog_busy),
        .phy_error   (phy_error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- cycle monitor (negedge sampling) ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int exp_start_dly = 0;   // 0 disables the settle-delay check
    int exp_rst_dly   = 0;   // 0 disables the abort-delay check
    logic [N-1:0] pin_prev = '0;
    logic [23:0]  pin_hist = '0;
    int last_pin_cyc = 0, last_start_cyc = 0;
    int n_starts = 0, n_rsts = 0, n_done = 0, n_pinchg = 0, done_cyc = 0;
    int multi_hot = 0, busy_pinchg = 0, start_dly_bad = 0, rst_dly_bad = 0;

    always @(negedge clk) begin
        if (pin_sel !== pin_prev) begin
            n_pinchg++;
            pin_hist = {pin_hist[19:0], pin_sel};
            last_pin_cyc = cyc;
            if ($countones(pin_sel) > 1) multi_hot++;
            if (prog_busy && !rst) busy_pinchg++;
            pin_prev = pin_sel;
        end
        if (prog_start) begin
            n_starts++;
            if (exp_start_dly != 0 && (cyc - last_pin_cyc) != exp_start_dly) start_dly_bad++;
            last_start_cyc = cyc;
        end
        if (prog_rst) begin
            n_rsts++;
            if (exp_rst_dly != 0 && (cyc - last_start_cyc) != exp_rst_dly) rst_dly_bad++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // ---------------- programmer model ----------------
    logic [11:0] cur_beh = '0;
    int          seq_id  = 0;

    task automatic hold(input int n, input bit err);
        prog_busy = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (rst || prog_rst) break;
            phy_error = err && (k == 10);
        end
        prog_busy = 1'b0;
        phy_error = 1'b0;
    endtask

    initial begin : prog_model
        int att [4];
        int seen;
        int t;
        int a;
        logic [2:0] b;
        seen = -1;
        prog_busy = 1'b0;
        phy_error = 1'b0;
        forever begin
            @(negedge clk);
            if (prog_start && !rst) begin
                if (seen != seq_id) begin
                    for (int k = 0; k < 4; k++) att[k] = 0;
                    seen = seq_id;
                end
                t = int'(cur_target);
                b = cur_beh[t*3 +: 3];
                a = att[t];
                att[t] = a + 1;
                case (b)
                    B_OK:    hold(50, 1'b0);
                    B_ERR1:  hold(50, a == 0);
                    B_STUCK: hold(5000, 1'b0);
                    B_EDGE:  hold(RUN_T + 1, 1'b0);
                    default: ;
                endcase
            end
        end
    end

    // ---------------- sequence runner ----------------
    int base_starts, base_rsts, base_pinchg, base_done, base_sbad, base_rbad, t_start;

    task automatic run_seq(input logic [N-1:0] m, input logic [11:0] beh);
        int waited;
        cur_beh = beh;
        seq_id++;
        base_starts = n_starts;
        base_rsts   = n_rsts;
        base_pinchg = n_pinchg;
        base_done   = n_done;
        base_sbad   = start_dly_bad;
        base_rbad   = rst_dly_bad;
        @(negedge clk);
        start = 1'b1;
        target_mask = m;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        target_mask = '0;
        waited = 0;
        while (n_done == base_done && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        check("done_seen", 32'(n_done != base_done), 32'd1);
    endtask

    typedef struct {
        logic [N-1:0] mask;
        logic [11:0]  beh;
        logic [N-1:0] exp_pass;
        logic [N-1:0] exp_fail;
        int           exp_starts;
        int           exp_rsts;
        int           exp_pinchg;
        int           exp_rst_dly;
        bit           chk_settle;
    } vec_t;

    vec_t vecs [7];

    initial begin : test
        vecs[0] = '{4'b1011, 12'h000, 4'b1011, 4'b0000, 3, 0, 6, 0, 1'b1};
        vecs[1] = '{4'b0001, 12'h001, 4'b0001, 4'b0000, 2, 0, 2, 0, 1'b0};
        vecs[2] = '{4'b0011, 12'h002, STOP ? 4'b0000 : 4'b0010, 4'b0001,
                    STOP ? 3 : 4, 3, STOP ? 2 : 4, BUSY_T + 1, 1'b0};
        vecs[3] = '{4'b0100, 12'h0C0, 4'b0000, 4'b0100, 3, 3, 2, RUN_T + 2, 1'b0};
        vecs[4] = '{4'b1000, 12'h800, 4'b1000, 4'b0000, 1, 0, 2, 0, 1'b1};
        vecs[5] = '{4'b0000, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0};
        vecs[6] = '{4'b1111, 12'h050, STOP ? 4'b0001 : 4'b1101, 4'b0010,
                    STOP ? 4 : 7, 3, STOP ? 4 : 8, BUSY_T + 1, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        target_mask = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              32'({busy, done, pass_mask, fail_mask, cur_target, pin_sel, prog_rst, prog_start}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            exp_start_dly = vecs[i].chk_settle ? SETTLE_T : 0;
            exp_rst_dly   = vecs[i].exp_rst_dly;
            run_seq(vecs[i].mask, vecs[i].beh);
            check($sformatf("v%0d_pass_mask", i), 32'(pass_mask), 32'(vecs[i].exp_pass));
            check($sformatf("v%0d_fail_mask", i), 32'(fail_mask), 32'(vecs[i].exp_fail));
            check($sformatf("v%0d_starts", i), 32'(n_starts - base_starts), 32'(vecs[i].exp_starts));
            check($sformatf("v%0d_prog_rsts", i), 32'(n_rsts - base_rsts), 32'(vecs[i].exp_rsts));
            check($sformatf("v%0d_pin_changes", i), 32'(n_pinchg - base_pinchg), 32'(vecs[i].exp_pinchg));
            check($sformatf("v%0d_done_pulses", i), 32'(n_done - base_done), 32'd1);
            check($sformatf("v%0d_busy_after", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_settle_delay_bad", i), 32'(start_dly_bad - base_sbad), 32'd0);
            check($sformatf("v%0d_rst_delay_bad", i), 32'(rst_dly_bad - base_rbad), 32'd0);
            if (i == 0) begin
                check("v0_pin_order", 32'(pin_hist), 32'h102080);
            end
            if (i == 5) begin
                check("v5_empty_done_delay", 32'(done_cyc - t_start), 32'(N + 2));
            end
            repeat (3) @(negedge clk);
        end
        exp_start_dly = 0;
        exp_rst_dly   = 0;

        // Reset in the middle of target 1's run, after an ignored start request.
        begin : mid_reset
            int waited;
            cur_beh = '0;
            seq_id++;
            base_starts = n_starts;
            @(negedge clk);
            start = 1'b1;
            target_mask = 4'b0011;
            @(negedge clk);
            start = 1'b0;
            target_mask = '0;
            waited = 0;
            while (n_starts < base_starts + 2 && waited < 1000) begin
                @(negedge clk);
                waited++;
            end
            check("mid_second_start_seen", 32'(n_starts - base_starts), 32'd2);
            repeat (10) @(negedge clk);
            check("mid_pass_mask", 32'(pass_mask), 32'b0001);
            check("mid_pin_sel", 32'(pin_sel), 32'b0010);
            check("mid_cur_target", 32'(cur_target), 32'd1);
            start = 1'b1;
            target_mask = 4'b1111;
            @(negedge clk);
            start = 1'b0;
            target_mask = '0;
            @(negedge clk);
            check("ignored_start_pass", 32'(pass_mask), 32'b0001);
            check("ignored_start_fail", 32'(fail_mask), 32'b0000);
            check("ignored_start_cur", 32'(cur_target), 32'd1);
            @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            check("async_reset_outputs",
                  32'({busy, done, pass_mask, fail_mask, cur_target, pin_sel, prog_rst, prog_start}), 32'd0);
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (2) @(negedge clk);
        end

        run_seq(4'b0001, 12'h000);
        check("post_reset_pass", 32'(pass_mask), 32'b0001);
        check("post_reset_fail", 32'(fail_mask), 32'b0000);

        check("pin_multi_hot", 32'(multi_hot), 32'd0);
        check("pin_change_while_busy", 32'(busy_pinchg), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : global_timeout
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got %0d checks, expected completion", n_tests);
        $fatal(1);
    end

endmodule
